// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
//   ADDR_W/DATA_W/BE_W : bus field widths
//   IF_BE              : byte enables used for every instruction fetch
//   arb_state_t        : arbiter FSM encoding
//   bus_cmd_t          : registered bus command payload
package mem_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [BE_W-1:0] IF_BE = {BE_W{1'b1}};

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GNT_IF = 2'd1,
        ARB_GNT_LS = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } bus_cmd_t;

endpackage

// File: rtl/bus_watchdog.sv
// Access watchdog: counts cycles while enabled and flags the cycle in which
// the count reaches TIMEOUT-1.
//   i_CLK, i_RSTn : clock, synchronous active-low reset
//   i_CLR         : clear the count (held while no access is granted)
//   i_EN          : count enable (access in progress)
//   o_EXPIRE      : combinational, high while enabled at the last allowed cycle
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic i_CLK,
    input  logic i_RSTn,
    input  logic i_CLR,
    input  logic i_EN,
    output logic o_EXPIRE
);

    localparam int unsigned      CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Counter holds at LAST so it can never wrap back to an early value.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            r_count <= '0;
        end else if (i_CLR) begin
            r_count <= '0;
        end else if (i_EN && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_EXPIRE = i_EN && (r_count == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master bus arbiter: instruction fetch (IF) and load/store (LS) share
// one slave port, one outstanding access at a time. LS has priority; after
// LS_STREAK_MAX consecutive LS grants taken while IF waits, IF is forced
// through. A watchdog terminates accesses the slave never answers.
//   i_CLK, i_RSTn                 : clock, synchronous active-low reset
//   i_IF_* / o_IF_*               : fetch master request and completion
//   i_LS_* / o_LS_*               : load/store master request and completion
//   o_BUS_*                       : registered command to the slave
//   i_BUS_RDATA/ACK/ERR           : slave response
// Completion outputs (ACK/ERR/RDATA) are combinational from the slave response.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT       = 64,
    parameter int unsigned LS_STREAK_MAX = 4
) (
    input  logic              i_CLK,
    input  logic              i_RSTn,
    input  logic              i_IF_REQ,
    input  logic [ADDR_W-1:0] i_IF_ADDR,
    output logic [DATA_W-1:0] o_IF_RDATA,
    output logic              o_IF_ACK,
    output logic              o_IF_ERR,
    input  logic              i_LS_REQ,
    input  logic              i_LS_WE,
    input  logic [ADDR_W-1:0] i_LS_ADDR,
    input  logic [DATA_W-1:0] i_LS_WDATA,
    input  logic [BE_W-1:0]   i_LS_BE,
    output logic [DATA_W-1:0] o_LS_RDATA,
    output logic              o_LS_ACK,
    output logic              o_LS_ERR,
    output logic              o_BUS_REQ,
    output logic              o_BUS_WE,
    output logic [ADDR_W-1:0] o_BUS_ADDR,
    output logic [DATA_W-1:0] o_BUS_WDATA,
    output logic [BE_W-1:0]   o_BUS_BE,
    input  logic [DATA_W-1:0] i_BUS_RDATA,
    input  logic              i_BUS_ACK,
    input  logic              i_BUS_ERR
);

    localparam int unsigned         STREAK_W   = $clog2(LS_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(LS_STREAK_MAX);

    arb_state_t          r_state;
    logic [STREAK_W-1:0] r_streak;
    bus_cmd_t            r_cmd;
    logic                r_bus_req;

    logic     w_granted;
    logic     w_wd_hit;
    logic     w_slave_done;
    logic     w_wd_expire;
    logic     w_done;
    logic     w_err;
    logic     w_pick_if;
    logic     w_pick_ls;
    bus_cmd_t w_if_cmd;
    bus_cmd_t w_ls_cmd;

    assign w_granted = (r_state != ARB_IDLE);

    // Watchdog is cleared every idle cycle, so the count starts at 0 on the
    // first granted cycle.
    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_CLK    (i_CLK),
        .i_RSTn   (i_RSTn),
        .i_CLR    (!w_granted),
        .i_EN     (w_granted),
        .o_EXPIRE (w_wd_hit)
    );

    // A slave answer in the expiry cycle wins over the timeout.
    assign w_slave_done = i_BUS_ACK | i_BUS_ERR;
    assign w_wd_expire  = w_wd_hit & ~w_slave_done;
    assign w_done       = w_granted & (w_slave_done | w_wd_hit);
    assign w_err        = i_BUS_ERR | w_wd_expire;

    // IF wins when alone, or when LS has used up its streak while IF waited.
    assign w_pick_if = i_IF_REQ & (~i_LS_REQ | (r_streak == STREAK_SAT));
    assign w_pick_ls = i_LS_REQ & ~w_pick_if;

    assign w_if_cmd = '{we: 1'b0, addr: i_IF_ADDR, wdata: '0, be: IF_BE};
    assign w_ls_cmd = '{we: i_LS_WE, addr: i_LS_ADDR, wdata: i_LS_WDATA, be: i_LS_BE};

    // Arbitration FSM, streak counter and registered bus command.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            r_state   <= ARB_IDLE;
            r_streak  <= '0;
            r_cmd     <= '0;
            r_bus_req <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_ls) begin
                        r_state   <= ARB_GNT_LS;
                        r_cmd     <= w_ls_cmd;
                        r_bus_req <= 1'b1;
                        if (!i_IF_REQ) begin
                            r_streak <= '0;
                        end else if (r_streak != STREAK_SAT) begin
                            r_streak <= r_streak + STREAK_W'(1);
                        end
                    end else if (w_pick_if) begin
                        r_state   <= ARB_GNT_IF;
                        r_cmd     <= w_if_cmd;
                        r_bus_req <= 1'b1;
                        r_streak  <= '0;
                    end
                end
                ARB_GNT_IF, ARB_GNT_LS: begin
                    if (w_done) begin
                        r_state   <= ARB_IDLE;
                        r_bus_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_BUS_REQ   = r_bus_req;
    assign o_BUS_WE    = r_cmd.we;
    assign o_BUS_ADDR  = r_cmd.addr;
    assign o_BUS_WDATA = r_cmd.wdata;
    assign o_BUS_BE    = r_cmd.be;

    assign o_IF_ACK   = (r_state == ARB_GNT_IF) & w_done;
    assign o_IF_ERR   = (r_state == ARB_GNT_IF) & w_done & w_err;
    assign o_IF_RDATA = i_BUS_RDATA;

    assign o_LS_ACK   = (r_state == ARB_GNT_LS) & w_done;
    assign o_LS_ERR   = (r_state == ARB_GNT_LS) & w_done & w_err;
    assign o_LS_RDATA = i_BUS_RDATA;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter. The stimulus process
// decides per round which master should win and how the slave answers,
// and queues the expected grant and completion; a negedge monitor checks
// the DUT against those queues.
module tb_mem_bus_arbiter;

    localparam int TIMEOUT = 64;
    localparam int STREAK  = 4;

    logic        i_CLK = 1'b0;
    logic        i_RSTn = 1'b0;
    logic        i_IF_REQ = 1'b0;
    logic [31:0] i_IF_ADDR = '0;
    logic [31:0] o_IF_RDATA;
    logic        o_IF_ACK, o_IF_ERR;
    logic        i_LS_REQ = 1'b0;
    logic        i_LS_WE = 1'b0;
    logic [31:0] i_LS_ADDR = '0;
    logic [31:0] i_LS_WDATA = '0;
    logic [3:0]  i_LS_BE = '0;
    logic [31:0] o_LS_RDATA;
    logic        o_LS_ACK, o_LS_ERR;
    logic        o_BUS_REQ, o_BUS_WE;
    logic [31:0] o_BUS_ADDR, o_BUS_WDATA;
    logic [3:0]  o_BUS_BE;
    logic [31:0] i_BUS_RDATA = '0;
    logic        i_BUS_ACK = 1'b0;
    logic        i_BUS_ERR = 1'b0;

    mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .LS_STREAK_MAX(STREAK)) dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn),
        .i_IF_REQ(i_IF_REQ), .i_IF_ADDR(i_IF_ADDR),
        .o_IF_RDATA(o_IF_RDATA), .o_IF_ACK(o_IF_ACK), .o_IF_ERR(o_IF_ERR),
        .i_LS_REQ(i_LS_REQ), .i_LS_WE(i_LS_WE), .i_LS_ADDR(i_LS_ADDR),
        .i_LS_WDATA(i_LS_WDATA), .i_LS_BE(i_LS_BE),
        .o_LS_RDATA(o_LS_RDATA), .o_LS_ACK(o_LS_ACK), .o_LS_ERR(o_LS_ERR),
        .o_BUS_REQ(o_BUS_REQ), .o_BUS_WE(o_BUS_WE), .o_BUS_ADDR(o_BUS_ADDR),
        .o_BUS_WDATA(o_BUS_WDATA), .o_BUS_BE(o_BUS_BE),
        .i_BUS_RDATA(i_BUS_RDATA), .i_BUS_ACK(i_BUS_ACK), .i_BUS_ERR(i_BUS_ERR)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          cyc;
    } grant_t;

    typedef struct {
        bit          ls;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } comp_t;

    grant_t grant_q[$];
    comp_t  comp_q[$];
    grant_t cur_g;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;
    bit  prev_req = 1'b0;
    bit  if_pend = 1'b0;
    bit  ls_pend = 1'b0;
    int  streak = 0;

    always @(posedge i_CLK) cyc <= cyc + 1;

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    // Monitor: grants, bus stability, completions and the ACK/ERR protocol.
    always @(negedge i_CLK) begin
        if (mon_en) begin
            if (o_BUS_REQ && !prev_req) begin
                tests++;
                if (grant_q.size() == 0) begin
                    fails++;
                    $display("FAIL grant_unexpected: got addr=%h at cyc %0d, required no grant", o_BUS_ADDR, cyc);
                end else begin
                    cur_g = grant_q.pop_front();
                    if (o_BUS_WE !== cur_g.we || o_BUS_ADDR !== cur_g.addr ||
                        o_BUS_WDATA !== cur_g.wdata || o_BUS_BE !== cur_g.be || cyc != cur_g.cyc) begin
                        fails++;
                        $display("FAIL grant: got we=%b addr=%h wd=%h be=%h cyc=%0d, required we=%b addr=%h wd=%h be=%h cyc=%0d",
                                 o_BUS_WE, o_BUS_ADDR, o_BUS_WDATA, o_BUS_BE, cyc,
                                 cur_g.we, cur_g.addr, cur_g.wdata, cur_g.be, cur_g.cyc);
                    end
                end
            end else if (o_BUS_REQ) begin
                tests++;
                if (o_BUS_WE !== cur_g.we || o_BUS_ADDR !== cur_g.addr ||
                    o_BUS_WDATA !== cur_g.wdata || o_BUS_BE !== cur_g.be) begin
                    fails++;
                    $display("FAIL bus_stable: got we=%b addr=%h be=%h, required we=%b addr=%h be=%h at cyc %0d",
                             o_BUS_WE, o_BUS_ADDR, o_BUS_BE, cur_g.we, cur_g.addr, cur_g.be, cyc);
                end
            end
            if (o_IF_ACK || o_LS_ACK) begin
                comp_t c;
                tests++;
                if (comp_q.size() == 0) begin
                    fails++;
                    $display("FAIL ack_unexpected: got if_ack=%b ls_ack=%b at cyc %0d, required none", o_IF_ACK, o_LS_ACK, cyc);
                end else begin
                    logic        g_err;
                    logic [31:0] g_rd;
                    c     = comp_q.pop_front();
                    g_err = c.ls ? o_LS_ERR : o_IF_ERR;
                    g_rd  = c.ls ? o_LS_RDATA : o_IF_RDATA;
                    if (o_LS_ACK !== c.ls || o_IF_ACK !== !c.ls || g_err !== c.err ||
                        g_rd !== c.rdata || cyc != c.cyc) begin
                        fails++;
                        $display("FAIL completion: got ls_ack=%b if_ack=%b err=%b rd=%h cyc=%0d, required ls=%b err=%b rd=%h cyc=%0d",
                                 o_LS_ACK, o_IF_ACK, g_err, g_rd, cyc, c.ls, c.err, c.rdata, c.cyc);
                    end
                end
            end
            tests++;
            if ((o_IF_ERR && !o_IF_ACK) || (o_LS_ERR && !o_LS_ACK)) begin
                fails++;
                $display("FAIL err_without_ack: got if=%b/%b ls=%b/%b at cyc %0d, required ERR only with ACK",
                         o_IF_ACK, o_IF_ERR, o_LS_ACK, o_LS_ERR, cyc);
            end
            prev_req = o_BUS_REQ;
        end
    end

    // One arbitration round, entered just after an edge with the arbiter idle.
    // kind: 0 ack, 1 err, 2 ack+err, 3 no answer (timeout), 4 ack in last allowed cycle
    task automatic round(input bit raise_if, input bit raise_ls, input bit late_ack,
                         input int kind, input int lat);
        bit          win_ls;
        int          g;
        int          n;
        logic [31:0] rd;
        if (raise_if && !if_pend) begin
            if_pend   = 1'b1;
            i_IF_REQ  = 1'b1;
            i_IF_ADDR = $urandom;
        end
        if (raise_ls && !ls_pend) begin
            ls_pend    = 1'b1;
            i_LS_REQ   = 1'b1;
            i_LS_WE    = 1'($urandom);
            i_LS_ADDR  = $urandom;
            i_LS_WDATA = $urandom;
            i_LS_BE    = 4'($urandom);
        end
        i_BUS_ACK   = late_ack;
        i_BUS_RDATA = $urandom;
        if (!if_pend && !ls_pend) begin
            step();
            i_BUS_ACK = 1'b0;
            return;
        end
        win_ls = ls_pend && (!if_pend || streak != STREAK);
        if (win_ls) streak = if_pend ? ((streak < STREAK) ? streak + 1 : STREAK) : 0;
        else        streak = 0;
        g = cyc + 1;
        if (win_ls) grant_q.push_back('{i_LS_WE, i_LS_ADDR, i_LS_WDATA, i_LS_BE, g});
        else        grant_q.push_back('{1'b0, i_IF_ADDR, 32'h0, 4'hF, g});
        rd = $urandom;
        n  = (kind == 3 || kind == 4) ? TIMEOUT - 1 : lat;
        comp_q.push_back('{win_ls, (kind == 1 || kind == 2 || kind == 3), rd, g + n});
        step();
        i_BUS_ACK   = 1'b0;
        i_BUS_RDATA = rd;
        for (int j = 0; j < n; j++) step();
        if (kind != 3) begin
            i_BUS_ACK = (kind != 1);
            i_BUS_ERR = (kind == 1 || kind == 2);
        end
        step();
        i_BUS_ACK = 1'b0;
        i_BUS_ERR = 1'b0;
        if (win_ls) begin ls_pend = 1'b0; i_LS_REQ = 1'b0; end
        else        begin if_pend = 1'b0; i_IF_REQ = 1'b0; end
    endtask

    initial begin
        int r;
        int k;
        int g;
        // Reset values
        step(); step(); step();
        @(negedge i_CLK);
        tests++;
        if (o_BUS_REQ !== 1'b0 || o_BUS_WE !== 1'b0 || o_BUS_ADDR !== '0 || o_BUS_WDATA !== '0 ||
            o_BUS_BE !== '0 || o_IF_ACK !== 1'b0 || o_IF_ERR !== 1'b0 || o_LS_ACK !== 1'b0 || o_LS_ERR !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got req=%b we=%b addr=%h be=%h acks=%b%b%b%b, required all zero",
                     o_BUS_REQ, o_BUS_WE, o_BUS_ADDR, o_BUS_BE, o_IF_ACK, o_IF_ERR, o_LS_ACK, o_LS_ERR);
        end
        @(posedge i_CLK);
        #1;
        i_RSTn = 1'b1;
        mon_en = 1'b1;

        // Both masters in the same cycle, then an IF-only fetch with a one-cycle slave
        round(1'b1, 1'b1, 1'b0, 0, 0);
        round(1'b0, 1'b0, 1'b0, 0, 1);
        round(1'b1, 1'b0, 1'b0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if      (r < 12) k = 0;
            else if (r < 15) k = 1;
            else if (r < 17) k = 2;
            else if (r == 17) k = 3;
            else if (r == 18) k = 4;
            else k = 0;
            round(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0), k, $urandom_range(0, 3));
        end

        // Drain pending masters
        for (int i = 0; i < 3; i++) round(1'b0, 1'b0, 1'b0, 0, 0);

        // Reset in the third granted cycle of an LS access
        i_LS_REQ   = 1'b1;
        i_LS_WE    = 1'b0;
        i_LS_ADDR  = 32'h2000_0040;
        i_LS_WDATA = 32'h0;
        i_LS_BE    = 4'hF;
        g = cyc + 1;
        grant_q.push_back('{1'b0, 32'h2000_0040, 32'h0, 4'hF, g});
        step(); step(); step();
        i_RSTn   = 1'b0;
        i_LS_REQ = 1'b0;
        step();
        @(negedge i_CLK);
        tests++;
        if (o_BUS_REQ !== 1'b0 || o_LS_ACK !== 1'b0 || o_IF_ACK !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got req=%b ls_ack=%b if_ack=%b, required 0 0 0", o_BUS_REQ, o_LS_ACK, o_IF_ACK);
        end
        @(posedge i_CLK);
        #1;
        i_RSTn = 1'b1;
        streak = 0;
        round(1'b1, 1'b0, 1'b0, 0, 1);
        step(); step();

        tests++;
        if (grant_q.size() != 0 || comp_q.size() != 0) begin
            fails++;
            $display("FAIL queues_drained: got %0d grants %0d completions outstanding, required 0 0",
                     grant_q.size(), comp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
